// File: rtl/program_loader.sv
// Program RAM writer: parses a framed byte stream from the UART receiver
// (HEADER, COUNT_HI, COUNT_LO, COUNT words high byte first, CHECK) and writes
// 16-bit words into program RAM while holding the core in reset.
//
// Handshake: rx_ready is a one-cycle strobe qualifying rx_data; there is no
// back-pressure, so every strobe is consumed in the cycle it arrives.
// mem_write_enable is a one-cycle strobe qualifying mem_address/mem_data_out.
module program_loader #(
    parameter int          DEPTH      = 1024,
    parameter int          ADDR_WIDTH = 10,
    parameter logic [23:0] TIMEOUT    = 24'd12_000_000,
    parameter logic [7:0]  HEADER     = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [15:0]           mem_data_out,
    output logic                  mem_write_enable,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [3:0] {
        S_IDLE, S_COUNT_HI, S_COUNT_LO, S_DATA_HI, S_DATA_LO,
        S_CHECKSUM, S_DONE, S_ERROR
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t                  state_q, state_d;
    logic [7:0]              count_hi_q, count_hi_d;
    logic [15:0]             remaining_q, remaining_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              hi_q, hi_d;
    logic [7:0]              sum_q, sum_d;
    logic [23:0]             timer_q, timer_d;
    logic [ADDR_WIDTH-1:0]   mem_address_q, mem_address_d;
    logic [15:0]             mem_data_q, mem_data_d;
    logic                    we_q, we_d;
    logic                    hold_q, hold_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;

    logic                    in_frame;
    logic [15:0]             count_full;

    // Register all state and outputs; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            count_hi_q    <= '0;
            remaining_q   <= '0;
            addr_q        <= '0;
            hi_q          <= '0;
            sum_q         <= '0;
            timer_q       <= '0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            we_q          <= 1'b0;
            hold_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_hi_q    <= count_hi_d;
            remaining_q   <= remaining_d;
            addr_q        <= addr_d;
            hi_q          <= hi_d;
            sum_q         <= sum_d;
            timer_q       <= timer_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            we_q          <= we_d;
            hold_q        <= hold_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

    // Frame parser: next state, running checksum, word assembly and timeout.
    always_comb begin
        state_d       = state_q;
        count_hi_d    = count_hi_q;
        remaining_d   = remaining_q;
        addr_d        = addr_q;
        hi_d          = hi_q;
        sum_d         = sum_q;
        timer_d       = timer_q;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        we_d          = 1'b0;
        hold_d        = hold_q;
        done_d        = 1'b0;
        error_d       = error_q;
        count_full    = {count_hi_q, rx_data};

        in_frame = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
        if (in_frame) begin
            timer_d = rx_ready ? 24'd0 : timer_q + 24'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (rx_ready && rx_data == HEADER) begin
                    state_d = S_COUNT_HI;
                    error_d = 1'b0;
                    addr_d  = '0;
                    sum_d   = '0;
                    timer_d = '0;
                    hold_d  = 1'b1;
                end
            end
            S_COUNT_HI: begin
                if (rx_ready) begin
                    count_hi_d = rx_data;
                    sum_d      = sum_q + rx_data;
                    state_d    = S_COUNT_LO;
                end
            end
            S_COUNT_LO: begin
                if (rx_ready) begin
                    sum_d       = sum_q + rx_data;
                    remaining_d = count_full;
                    if ({1'b0, count_full} > DEPTH_L) begin
                        state_d = S_ERROR;
                    end else if (count_full == 16'd0) begin
                        state_d = S_CHECKSUM;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (rx_ready) begin
                    hi_d    = rx_data;
                    sum_d   = sum_q + rx_data;
                    state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (rx_ready) begin
                    sum_d         = sum_q + rx_data;
                    mem_data_d    = {hi_q, rx_data};
                    mem_address_d = addr_q;
                    we_d          = 1'b1;
                    addr_d        = addr_q + 1'b1;
                    remaining_d   = remaining_q - 16'd1;
                    state_d       = (remaining_q == 16'd1) ? S_CHECKSUM : S_DATA_HI;
                end
            end
            S_CHECKSUM: begin
                if (rx_ready) begin
                    if (rx_data == sum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERROR: begin
                error_d = 1'b1;
                hold_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Silence inside a frame for TIMEOUT cycles abandons the frame.
        if (in_frame && !rx_ready && (timer_q + 24'd1 == TIMEOUT)) begin
            state_d = S_ERROR;
        end
    end

    assign mem_address      = mem_address_q;
    assign mem_data_out     = mem_data_q;
    assign mem_write_enable = we_q;
    assign cpu_hold         = hold_q;
    assign busy             = (state_q != S_IDLE);
    assign done             = done_q;
    assign error            = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: frame-level reference model producing expected
// RAM writes, done pulses and error outcome; per-cycle compare process.
module tb_program_loader;

  localparam int          DEPTH      = 1024;
  localparam int          ADDR_WIDTH = 10;
  localparam logic [23:0] TIMEOUT    = 24'd100;
  localparam logic [7:0]  HEADER     = 8'hA5;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic [7:0]            rx_data = 8'h00;
  logic                  rx_ready = 1'b0;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [15:0]           mem_data_out;
  logic                  mem_write_enable;
  logic                  cpu_hold;
  logic                  busy;
  logic                  done;
  logic                  error;

  program_loader #(
    .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .TIMEOUT(TIMEOUT), .HEADER(HEADER)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_ready(rx_ready),
    .mem_address(mem_address), .mem_data_out(mem_data_out),
    .mem_write_enable(mem_write_enable), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .error(error)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int exp_done_cnt = 0;
  logic exp_err = 1'b0;
  logic [25:0] exp_q[$];
  logic [7:0] frame_q[$];
  logic [25:0] cmp_e;
  logic prev_we = 1'b0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the expected write queue and pulse rules.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_we = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (mem_write_enable) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(mem_address), 32'hFFFF_FFFF);
        end else begin
          cmp_e = exp_q.pop_front();
          check("write_addr", 32'(mem_address), 32'(cmp_e[25:16]));
          check("write_data", 32'(mem_data_out), 32'(cmp_e[15:0]));
        end
        check("hold_during_write", 32'(cpu_hold), 32'd1);
      end
      if (done) begin
        done_cnt++;
        check("hold_at_done", 32'(cpu_hold), 32'd0);
      end
      if (prev_we) check("we_single_cycle", 32'(mem_write_enable), 32'd0);
      if (prev_done) check("done_single_cycle", 32'(done), 32'd0);
      prev_we = mem_write_enable;
      prev_done = done;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] frame_sum(input int last);
    logic [7:0] s = 8'h00;
    for (int i = 1; i <= last; i++) s = s + frame_q[i];
    return s;
  endfunction

  // Whole-frame outcome from the frame rules, queued before the frame is sent.
  task automatic model_frame();
    int cnt;
    cnt = int'({frame_q[1], frame_q[2]});
    if (cnt > DEPTH) begin
      exp_err = 1'b1;
    end else begin
      for (int w = 0; w < cnt; w++)
        exp_q.push_back({10'(w), frame_q[3 + 2 * w], frame_q[4 + 2 * w]});
      exp_err = (frame_q[3 + 2 * cnt] != frame_sum(2 + 2 * cnt));
      if (!exp_err) exp_done_cnt++;
    end
  endtask

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic post_checks(input string tag);
    idle(4);
    check({tag, "_error"}, 32'(error), 32'(exp_err));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_done_count"}, 32'(done_cnt), 32'(exp_done_cnt));
    check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_frame(input string tag, input int max_gap, input bit use_model);
    if (use_model) model_frame();
    for (int i = 0; i < frame_q.size(); i++) begin
      send_byte(frame_q[i]);
      if (i == 0) begin
        check({tag, "_hdr_error_clear"}, 32'(error), 32'd0);
        check({tag, "_hdr_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_hdr_busy"}, 32'(busy), 32'd1);
      end
      if (i != frame_q.size() - 1) idle($urandom_range(0, max_gap));
    end
    post_checks(tag);
  endtask

  task automatic build_frame(input int cnt, input bit good, input bit rand_data);
    frame_q.delete();
    frame_q.push_back(HEADER);
    frame_q.push_back(8'(cnt >> 8));
    frame_q.push_back(8'(cnt));
    for (int i = 0; i < 2 * cnt; i++)
      frame_q.push_back(rand_data ? 8'($urandom) : 8'(i * 7 + 3));
    frame_q.push_back(good ? frame_sum(2 + 2 * cnt) : frame_sum(2 + 2 * cnt) + 8'h01);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, 32'(mem_address), 32'd0);
    check({tag, "_data"}, 32'(mem_data_out), 32'd0);
    check({tag, "_we"}, 32'(mem_write_enable), 32'd0);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle(3);
    check_all_zero("reset");
    reset_n = 1'b1;
    idle(2);

    // Good frame A with literal expectations pinning the model.
    frame_q = '{8'hA5, 8'h00, 8'h02, 8'h80, 8'h00, 8'h00, 8'h15, 8'h97};
    check("model_checksum_literal", 32'(frame_sum(6)), 32'h97);
    exp_q.push_back({10'd0, 16'h8000});
    exp_q.push_back({10'd1, 16'h0015});
    exp_err = 1'b0;
    exp_done_cnt++;
    run_frame("frameA", 2, 1'b0);

    // Bad checksum: words still written, error latched, no done.
    frame_q = '{8'hA5, 8'h00, 8'h02, 8'h80, 8'h00, 8'h00, 8'h15, 8'h98};
    run_frame("badsum", 2, 1'b1);
    check("badsum_model_err", 32'(exp_err), 32'd1);

    // Oversize count (1025), then the largest illegal 16-bit count.
    frame_q = '{8'hA5, 8'h04, 8'h01};
    run_frame("oversize", 2, 1'b1);
    frame_q = '{8'hA5, 8'hFF, 8'hFF};
    run_frame("oversize_ffff", 1, 1'b1);

    // Leading garbage is ignored, then zero-count frame.
    send_byte(8'h11);
    check("garbage1_busy", 32'(busy), 32'd0);
    idle(1);
    send_byte(8'h22);
    check("garbage2_busy", 32'(busy), 32'd0);
    frame_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
    run_frame("zero", 1, 1'b1);
    check("zero_model_done", 32'(exp_err), 32'd0);

    // HEADER bytes inside the frame are data.
    frame_q = '{8'hA5, 8'h00, 8'h02, 8'hA5, 8'hA5, 8'h00, 8'hA5, 8'h00};
    frame_q[7] = frame_sum(6);
    run_frame("hdr_as_data", 0, 1'b1);

    // Timeout: A5 00 01 F0 then silence.
    frame_q.delete();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hF0);
    idle(int'(TIMEOUT) - 1);
    check("timeout_before_error", 32'(error), 32'd0);
    check("timeout_before_busy", 32'(busy), 32'd1);
    idle(2);
    check("timeout_error", 32'(error), 32'd1);
    check("timeout_busy", 32'(busy), 32'd0);
    check("timeout_hold", 32'(cpu_hold), 32'd0);
    check("timeout_no_write", 32'(exp_q.size()), 32'd0);
    check("timeout_done_count", 32'(done_cnt), 32'(exp_done_cnt));

    // Reset between the two bytes of word 1.
    exp_q.push_back({10'd0, 16'h1234});
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    idle(2);
    send_byte(8'h56);
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    idle(3);
    reset_n = 1'b1;
    check("midreset_writes_left", 32'(exp_q.size()), 32'd0);
    exp_err = 1'b0;
    idle(1);
    build_frame(3, 1'b1, 1'b1);
    run_frame("after_reset", 3, 1'b1);

    // Largest legal frame: last address DEPTH-1.
    build_frame(DEPTH, 1'b1, 1'b0);
    run_frame("full_depth", 0, 1'b1);

    // Randomized frames.
    for (int k = 0; k < 20; k++) begin
      build_frame($urandom_range(0, 6), ($urandom_range(0, 3) != 0), 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        send_byte(8'($urandom_range(0, 8'hA4)));
        idle(1);
      end
      run_frame("random", 3, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the program memory: receives a framed program image as a byte stream from the UART receiver and writes 16-bit words into the 1K×16 program RAM that the F100-L core fetches from.
- Holds the core in reset (cpu_hold) while loading.
- Validates the frame with a length field, a checksum and an inter-byte timeout.
- Replaces the hardcoded image for development builds.

Parameters:
- DEPTH, 1024, number of 16-bit words in program RAM; also the maximum word count accepted.
- ADDR_WIDTH, 10, width of mem_address.
- TIMEOUT, 24'd12_000_000, clk cycles allowed between bytes inside a frame before abort (1 s at 12 MHz).
- HEADER, 8'hA5, frame start byte.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- rx_data  input  8  byte from UART receiver.
- rx_ready  input  1  one-cycle strobe; rx_data valid this cycle.
- mem_address  output  ADDR_WIDTH  program RAM write address.
- mem_data_out  output  16  program RAM write data.
- mem_write_enable  output  1  one-cycle write strobe.
- cpu_hold  output  1  high while a frame is in progress; the core is held in reset.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse on successful load.
- error  output  1  latched high on a failed frame; cleared when the next HEADER is accepted.

Behaviour:
- Reset (asynchronous, reset_n low): all outputs 0, state IDLE, internal address/count/checksum/timer 0. Reset mid-frame aborts with no further writes; RAM contents already written remain.
- Frame format: HEADER, COUNT_HI, COUNT_LO, then COUNT words (each word high byte then low byte), then CHECK.
- CHECK = 8-bit modulo-256 sum of COUNT_HI, COUNT_LO and all data bytes. The header is excluded.
- State IDLE:
  - rx_ready with rx_data==HEADER -> COUNT_HI. Clears error, address, checksum and timer; sets cpu_hold.
  - Any other byte is ignored.
- State COUNT_HI: on byte, store the byte, add it to the checksum -> COUNT_LO.
- State COUNT_LO: on byte, store the byte, add it to the checksum. Then:
  - count > DEPTH -> ERROR.
  - count == 0 -> CHECKSUM.
  - otherwise -> DATA_HI.
- State DATA_HI: on byte, latch the high byte, add to checksum -> DATA_LO.
- State DATA_LO: on byte, add to checksum. In the next cycle assert mem_write_enable for exactly one cycle, with mem_data_out = {hi, lo} and mem_address = current word index.
  - Address increments after the write; decrement the remaining count.
  - Remaining count == 0 -> CHECKSUM, else -> DATA_HI.
  - A byte arriving in the write cycle is accepted normally as the next DATA_HI byte.
- Address wrap: cannot occur, because count <= DEPTH is enforced. The last legal address is DEPTH-1.
- State CHECKSUM: on byte:
  - equal to the running sum -> DONE.
  - mismatch -> ERROR.
- State DONE: for one cycle done=1, cpu_hold=0, busy=0 on the next cycle -> IDLE.
- State ERROR: error<=1, cpu_hold<=0 -> IDLE. The RAM is not rolled back.
- Timeout: a timer clears on every accepted rx_ready and increments each cycle in any state except IDLE/DONE/ERROR. Reaching TIMEOUT -> ERROR.
- A HEADER byte received mid-frame is treated as data, not as a restart.
- busy = (state != IDLE). Outputs are registered; there is no combinational path from rx_* to any output.

Test Plan:
- Good frame A5 00 02 80 00 00 15 97 -> writes 8000@0 then 0015@1, each a single-cycle enable; done pulses once; error=0; cpu_hold high from the header until DONE.
- Bad checksum: the same frame with CHECK=98 -> both words still written; error=1, done never pulses; the next A5 clears error.
- Oversize count A5 04 01 -> ERROR immediately after COUNT_LO; no writes; returns to IDLE.
- Zero count A5 00 00 00 -> no writes; done pulses. Leading garbage bytes 11 22 before the header are ignored.
- Timeout (bench TIMEOUT=100): A5 00 01 F0 then silence -> ERROR at 100 cycles after F0; no write occurs.
- Reset: assert reset_n=0 between the two bytes of word 1 -> all outputs 0 immediately; a subsequent full frame loads correctly starting at address 0.
